ifm_window_gen: RTL and testbench

// - Streams an input feature map (raster order, one pixel/beat) and produces 3x3 sliding windows for the PE array.
// - Each window is a 9-element vector that feeds the array's ifm_input bus directly; one accepted window = one MAC pass.
// - Stride 1, no padding: (IMG_W-2)*(IMG_H-2) windows per frame.
// - Storage: two IMG_W-deep line buffers plus a 3x3 shift-register window.

---
 rtl/ifm_window_gen.sv | 134 +++++++++++++
 tb/tb_ifm_window_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_window_gen.sv
// 3x3 sliding-window generator: raster pixel stream in, one 9-element window per output pixel out.
// Optional IFM_WIN_STALL_CNT_EN adds a saturating stall_cnt output counting back-pressure cycles.
module ifm_window_gen #(
    parameter int DATA_W   = 8,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int WIN_SIZE = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     pix_valid,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     pix_ready,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic signed [DATA_W-1:0] win_data [WIN_SIZE-1:0],
    output logic                     busy,
    output logic                     frame_done
`ifdef IFM_WIN_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_t;

    state_t                     state;
    logic [CW-1:0]              col;
    logic [RW-1:0]              row;
    logic signed [DATA_W-1:0]   lb0 [IMG_W];
    logic signed [DATA_W-1:0]   lb1 [IMG_W];
    logic signed [DATA_W-1:0]   win_r   [3][3];
    logic signed [DATA_W-1:0]   win_nxt [3][3];
    logic                       accept;
    logic                       emit;
    logic                       last_pix;

    assign pix_ready = (state == StStream) && (!win_valid || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign emit      = accept && (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix  = accept && (row == ROW_LAST) && (col == COL_LAST);
    assign busy      = (state != StIdle);

    // Window after shifting left and loading the new right column (oldest row on top).
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_nxt[r][0] = win_r[r][1];
            win_nxt[r][1] = win_r[r][2];
        end
        win_nxt[0][2] = lb1[col];
        win_nxt[1][2] = lb0[col];
        win_nxt[2][2] = pix_data;
    end

    // Line buffers carry no reset; every entry is rewritten before it is read for a window.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StIdle;
            col        <= '0;
            row        <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < WIN_SIZE; i++) win_data[i] <= '0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) win_r[r][c] <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StStream;
                        col   <= '0;
                        row   <= '0;
                    end
                end
                StStream: begin
                    if (last_pix) state <= StFlush;
                end
                StFlush: begin
                    if (!win_valid || win_ready) begin
                        state      <= StIdle;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase

            if (accept) begin
                win_r <= win_nxt;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end

            // A new window replaces a consumed one in the same edge; otherwise a handshake clears it.
            if (emit) begin
                win_valid <= 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++) win_data[3*r+c] <= win_nxt[r][c];
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

`ifdef IFM_WIN_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (state == StIdle && start) begin
            stall_cnt <= '0;
        end else if (win_valid && !win_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifm_window_gen.sv
// Directed bench for ifm_window_gen on a 4x4 frame with pixel value 4*row+col.
module tb_ifm_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WS = 9;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 start     = 1'b0;
    logic                 pix_valid = 1'b0;
    logic                 win_ready = 1'b1;
    logic signed [DW-1:0] pix_data  = '0;
    logic                 pix_ready;
    logic                 win_valid;
    logic                 busy;
    logic                 frame_done;
    logic signed [DW-1:0] win_data [WS-1:0];
`ifdef IFM_WIN_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    int vectors = 0;
    int fails   = 0;
    int got_n   = 0;
    int fd_cnt  = 0;
    int fd_busy_bad = 0;
    int stall_bad   = 0;
    int stall_seen  = 0;
    logic signed [DW-1:0] got [64][WS];

    int exp_win [4][WS] = '{'{0, 1, 2, 4, 5, 6, 8, 9, 10},
                            '{1, 2, 3, 5, 6, 7, 9, 10, 11},
                            '{4, 5, 6, 8, 9, 10, 12, 13, 14},
                            '{5, 6, 7, 9, 10, 11, 13, 14, 15}};

    ifm_window_gen #(
        .DATA_W   (DW),
        .IMG_W    (W),
        .IMG_H    (H),
        .WIN_SIZE (WS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_ready  (pix_ready),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef IFM_WIN_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Record every consumed window and frame_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && win_valid && win_ready && got_n < 64) begin
            for (int k = 0; k < WS; k++) got[got_n][k] = win_data[k];
            got_n = got_n + 1;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            if (busy) fd_busy_bad = fd_busy_bad + 1;
        end
    end

    function automatic int win_errs(input int base, input bit neg);
        int errs = 0;
        for (int w = 0; w < 4; w++) begin
            bit bad = 1'b0;
            for (int k = 0; k < WS; k++)
                if (int'(got[base+w][k]) != (neg ? -128 : exp_win[w][k])) bad = 1'b1;
            if (bad) errs++;
        end
        return errs;
    endfunction

    task automatic run_frame(input int gap_pct, input bit stall, input bit restart,
                             input bit neg, input int npix);
        int pix = 0;
        int cyc = 0;
        int stall_left = stall ? 5 : 0;
        int fd_base = fd_cnt;
        logic signed [DW-1:0] snap [WS];
        stall_bad  = 0;
        stall_seen = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (pix < npix && cyc < 400) begin
            pix_valid = ($urandom_range(99) >= gap_pct);
            pix_data  = neg ? 8'sh80 : DW'(pix);
            start     = restart && (pix == 5);
            win_ready = !(stall_left > 0 && win_valid);
            @(negedge clk);
            if (!win_ready) begin
                if (stall_left == 5) for (int k = 0; k < WS; k++) snap[k] = win_data[k];
                if (pix_ready !== 1'b0) stall_bad++;
                for (int k = 0; k < WS; k++) if (win_data[k] !== snap[k]) stall_bad++;
                stall_left--;
                stall_seen++;
            end
            if (pix_valid && pix_ready) pix++;
            @(posedge clk); #1;
            cyc++;
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        win_ready = 1'b1;
        if (npix == W * H) begin
            for (int i = 0; i < 20 && fd_cnt == fd_base; i++) begin
                @(posedge clk); #1;
            end
            repeat (3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        bit bad = 1'b0;
        vectors++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
        vectors++; if (win_valid !== 1'b0) begin fails++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
        vectors++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        for (int k = 0; k < WS; k++) if (win_data[k] !== '0) bad = 1'b1;
        vectors++; if (bad) begin fails++; $display("FAIL reset_win_data got %0d want 0", win_data[0]); end
    endtask

    task automatic test_continuous();
        int gb = got_n;
        int fb = fd_cnt;
        run_frame(0, 1'b0, 1'b0, 1'b0, W * H);
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL cont_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b0) !== 0) begin fails++; $display("FAIL cont_windows got %0d bad want 0", win_errs(gb, 1'b0)); end
        vectors++; if (fd_cnt - fb !== 1) begin fails++; $display("FAIL cont_frame_done got %0d pulses want 1", fd_cnt - fb); end
        vectors++; if (busy !== 1'b0) begin fails++; $display("FAIL cont_busy_after got %b want 0", busy); end
        vectors++; if (fd_busy_bad !== 0) begin fails++; $display("FAIL cont_busy_at_done got %0d want 0", fd_busy_bad); end
    endtask

    task automatic test_stall();
        int gb = got_n;
        run_frame(0, 1'b1, 1'b0, 1'b0, W * H);
        vectors++; if (stall_seen !== 5) begin fails++; $display("FAIL stall_cycles got %0d want 5", stall_seen); end
        vectors++; if (stall_bad !== 0) begin fails++; $display("FAIL stall_hold got %0d violations want 0", stall_bad); end
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL stall_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b0) !== 0) begin fails++; $display("FAIL stall_windows got %0d bad want 0", win_errs(gb, 1'b0)); end
`ifdef IFM_WIN_STALL_CNT_EN
        vectors++; if (stall_cnt !== 16'd5) begin fails++; $display("FAIL stall_cnt got %0d want 5", stall_cnt); end
`endif
    endtask

    task automatic test_gaps();
        int gb = got_n;
        run_frame(50, 1'b0, 1'b0, 1'b0, W * H);
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL gaps_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b0) !== 0) begin fails++; $display("FAIL gaps_windows got %0d bad want 0", win_errs(gb, 1'b0)); end
    endtask

    task automatic test_restart_ignored();
        int gb = got_n;
        int fb = fd_cnt;
        run_frame(0, 1'b0, 1'b1, 1'b0, W * H);
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL restart_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b0) !== 0) begin fails++; $display("FAIL restart_windows got %0d bad want 0", win_errs(gb, 1'b0)); end
        vectors++; if (fd_cnt - fb !== 1) begin fails++; $display("FAIL restart_frame_done got %0d want 1", fd_cnt - fb); end
    endtask

    task automatic test_reset_midframe();
        int gb = got_n;
        bit bad = 1'b0;
        run_frame(0, 1'b0, 1'b0, 1'b0, 7);
        vectors++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        vectors++; if (pix_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_pix_ready got %b want 0", pix_ready); end
        vectors++; if (win_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_win_valid got %b want 0", win_valid); end
        for (int k = 0; k < WS; k++) if (win_data[k] !== '0) bad = 1'b1;
        vectors++; if (bad) begin fails++; $display("FAIL mid_rst_win_data got %0d want 0", win_data[0]); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (got_n - gb !== 0) begin fails++; $display("FAIL mid_partial got %0d want 0", got_n - gb); end
        gb = got_n;
        run_frame(0, 1'b0, 1'b0, 1'b0, W * H);
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL mid_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b0) !== 0) begin fails++; $display("FAIL mid_windows got %0d bad want 0", win_errs(gb, 1'b0)); end
    endtask

    task automatic test_signed();
        int gb = got_n;
        run_frame(0, 1'b0, 1'b0, 1'b1, W * H);
        vectors++; if (got_n - gb !== 4) begin fails++; $display("FAIL signed_count got %0d want 4", got_n - gb); end
        vectors++; if (win_errs(gb, 1'b1) !== 0) begin fails++; $display("FAIL signed_windows got %0d bad want 0", win_errs(gb, 1'b1)); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_continuous();
        test_stall();
        test_gaps();
        test_restart_ignored();
        test_reset_midframe();
        test_signed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
